// File: rtl/pk8086_bus_pkg.sv
// Shared definitions for the pk8086 memory bus arbiter: FSM encoding, access kinds, lane merge.
package pk8086_bus_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD0    = 3'd1;
    localparam logic [2:0] ST_RD1    = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_WR     = 3'd5;
    localparam logic [2:0] ST_ACK    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_RD0    = ST_RD0,
        S_RD1    = ST_RD1,
        S_RMW_RD = ST_RMW_RD,
        S_RMW_WR = ST_RMW_WR,
        S_WR     = ST_WR,
        S_ACK    = ST_ACK
    } state_t;

    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_WORD = 1'b1;
    localparam logic ACC_RD   = 1'b0;
    localparam logic ACC_WR   = 1'b1;

    // Replace one byte lane of a memory word: hi=1 selects [15:8], hi=0 selects [7:0].
    function automatic logic [15:0] lane_merge(input logic [15:0] word,
                                               input logic [7:0]  b,
                                               input logic        hi);
        return hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single 16-bit word memory port,
// splitting unaligned accesses and doing read-modify-write for sub-word stores.
module mem_bus_arbiter
    import pk8086_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 20
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [15:0]   f_data,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_word,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_ack,
    output logic [15:0]   d_rdata,
    output logic [AW-1:0] m_addr,
    input  logic [15:0]   m_rdata,
    output logic [15:0]   m_wdata,
    output logic          m_wr,
    input  logic          m_ready
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t          r_state;
    logic            r_own_d;
    logic            r_we;
    logic            r_word;
    logic            r_phase;
    logic [AW-1:0]   r_addr;
    logic [15:0]     r_wdata;
    logic [7:0]      r_lo;
    logic [CW-1:0]   r_cnt;

    logic            w_starve;
    logic            w_grant_d;
    logic            w_grant_f;
    logic [AW-1:0]   w_g_addr;
    logic [AW-1:0]   w_addr_inc;
    logic [AW-1:0]   w_next_word;
    logic [15:0]     w_rd0_data;
    logic [15:0]     w_rd1_data;
    logic [7:0]      w_byte;
    logic            w_hi;
    logic [15:0]     w_merge;

    // D has priority unless F has waited through STARVE_LIMIT D grants.
    assign w_starve    = f_req && (r_cnt == CW'(STARVE_LIMIT));
    assign w_grant_d   = d_req && !w_starve;
    assign w_grant_f   = f_req && !w_grant_d;
    assign w_g_addr    = w_grant_d ? d_addr : f_addr;
    assign w_addr_inc  = r_addr + AW'(1);
    assign w_next_word = {w_addr_inc[AW-1:1], 1'b0};

    assign w_rd0_data = (r_word == ACC_BYTE)
                        ? {8'h00, (r_addr[0] ? m_rdata[15:8] : m_rdata[7:0])}
                        : m_rdata;
    assign w_rd1_data = {m_rdata[7:0], r_lo};

    // Unaligned word store: first word gets the low data byte in its high lane,
    // second word gets the high data byte in its low lane.
    always_comb begin
        w_byte = r_wdata[7:0];
        w_hi   = r_addr[0];
        if (r_word == ACC_WORD) begin
            w_byte = r_phase ? r_wdata[15:8] : r_wdata[7:0];
            w_hi   = !r_phase;
        end
    end

    assign w_merge = lane_merge(m_rdata, w_byte, w_hi);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_own_d <= 1'b0;
            r_we    <= ACC_RD;
            r_word  <= ACC_BYTE;
            r_phase <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wr    <= 1'b0;
            f_ack   <= 1'b0;
            f_data  <= '0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!f_req || w_grant_f) begin
                        r_cnt <= '0;
                    end else if (w_grant_d) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_grant_d || w_grant_f) begin
                        r_own_d <= w_grant_d;
                        r_we    <= w_grant_d ? d_we : ACC_RD;
                        r_word  <= w_grant_d ? d_word : ACC_WORD;
                        r_addr  <= w_g_addr;
                        r_wdata <= d_wdata;
                        r_phase <= 1'b0;
                        m_addr  <= {w_g_addr[AW-1:1], 1'b0};
                        if (w_grant_d && (d_we == ACC_WR) && (d_word == ACC_WORD) && !d_addr[0]) begin
                            m_wdata <= d_wdata;
                            m_wr    <= 1'b1;
                            r_state <= S_WR;
                        end else if (w_grant_d && (d_we == ACC_WR)) begin
                            r_state <= S_RMW_RD;
                        end else begin
                            r_state <= S_RD0;
                        end
                    end
                end
                S_RD0: begin
                    if (m_ready) begin
                        if ((r_word == ACC_WORD) && r_addr[0]) begin
                            r_lo    <= m_rdata[15:8];
                            m_addr  <= w_next_word;
                            r_state <= S_RD1;
                        end else begin
                            r_state <= S_ACK;
                            if (r_own_d) begin
                                d_ack   <= 1'b1;
                                d_rdata <= w_rd0_data;
                            end else begin
                                f_ack  <= 1'b1;
                                f_data <= w_rd0_data;
                            end
                        end
                    end
                end
                S_RD1: begin
                    if (m_ready) begin
                        r_state <= S_ACK;
                        if (r_own_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= w_rd1_data;
                        end else begin
                            f_ack  <= 1'b1;
                            f_data <= w_rd1_data;
                        end
                    end
                end
                S_RMW_RD: begin
                    if (m_ready) begin
                        m_wdata <= w_merge;
                        m_wr    <= 1'b1;
                        r_state <= S_RMW_WR;
                    end
                end
                S_RMW_WR: begin
                    if (m_ready) begin
                        m_wr <= 1'b0;
                        if ((r_word == ACC_WORD) && !r_phase) begin
                            r_phase <= 1'b1;
                            m_addr  <= w_next_word;
                            r_state <= S_RMW_RD;
                        end else begin
                            d_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end
                    end
                end
                S_WR: begin
                    if (m_ready) begin
                        m_wr    <= 1'b0;
                        d_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    m_wr    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit word memory port of the pk8086 core between two requesters: the instruction fetch unit (F) and the execution/data unit (D).
- Converts byte-addressed byte or word accesses, aligned or not, into whole-word memory cycles.
  - Unaligned word accesses are split into two memory cycles.
  - Sub-word writes are done as read-modify-write, because memory has no byte enables.
- Sits between the core sequencer and the external memory controller that drives m_ready.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while f_req is pending before one F grant is forced.
- AW, 20: byte address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  AW  fetch byte address; always a 2-byte fetch
- f_ack  out  1  one-cycle completion pulse for F
- f_data  out  16  {byte[f_addr+1], byte[f_addr]}; valid while f_ack=1
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=write, 0=read
- d_word  in  1  1=16-bit access, 0=8-bit access
- d_addr  in  AW  data byte address
- d_wdata  in  16  write data; byte accesses use [7:0]
- d_ack  out  1  one-cycle completion pulse for D
- d_rdata  out  16  read data, little-endian; byte reads are zero-extended; valid while d_ack=1
- m_addr  out  AW  memory word address; bit 0 is always 0
- m_rdata  in  16  memory read word
- m_wdata  out  16  memory write word
- m_wr  out  1  write strobe
- m_ready  in  1  current memory cycle completes at this clock edge

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE; starvation counter cleared.
  - m_addr, m_wdata, f_data and d_rdata go to 0; m_wr, f_ack and d_ack go to 0.
  - Reset mid-operation aborts the access: no ack is issued and m_wr drops immediately.
- All outputs are registered.
- FSM states:
  - IDLE: arbitration. Requester fields are latched and m_addr/m_wr are loaded for the first cycle.
  - RD0: first word of a read.
  - RD1: second word of an unaligned word read.
  - RMW_RD: read phase of a merge.
  - RMW_WR: write phase of a merge.
  - WR: full aligned word write.
  - ACK: ack pulse; no arbitration in this cycle.
- Every bus state holds m_addr, m_wdata and m_wr steady until the edge where m_ready=1, then advances.
- Arbitration, evaluated only in IDLE:
  - D beats F.
  - If f_req=1 and the counter equals STARVE_LIMIT, F wins.
  - Counter increments on each D grant while f_req=1, and clears on an F grant or when f_req=0.
- Read (F, or D with d_we=0), with a = latched address:
  - Aligned word (a[0]=0): RD0 at a → ACK.
  - Unaligned word: RD0 at a&~1 gives the low byte from m_rdata[15:8]. RD1 at a+1 gives the high byte from m_rdata[7:0] → ACK.
  - Byte: RD0, then select m_rdata[15:8] if a[0]=1, else m_rdata[7:0].
- Write (D only):
  - Aligned word: WR with m_wdata=d_wdata → ACK.
  - Byte: RMW_RD reads the word, then RMW_WR writes it with the lane a[0] replaced by d_wdata[7:0] → ACK.
  - Unaligned word: RMW on word a&~1 with the high lane ← d_wdata[7:0], then RMW on word a+1 with the low lane ← d_wdata[15:8]. That is four memory cycles → ACK.
- Address arithmetic is modulo 2^AW: an access at 0xFFFFF takes its second byte from 0x00000.
- ACK state:
  - Exactly one ack pulses, with its data.
  - Next state is IDLE.
  - The requester deasserts req or presents a new request in the cycle after ack; the arbiter samples requests again only in IDLE.
- Latency with m_ready tied to 1:
  - Request first visible in IDLE at cycle N.
  - Ack at N+2 for an aligned read or word write.
  - Ack at N+3 for an unaligned read or byte write.
  - Ack at N+5 for an unaligned word write.
  - Each m_ready=0 cycle adds one cycle.
- F and D requesting in the same IDLE cycle: D is served unless the starvation rule applies; F remains pending.
- Requests that change in mid-access are ignored; the fields latched in IDLE are used.

Decomposition:
- Package pk8086_bus_pkg:
  - FSM state encoding (3-bit localparams).
  - Access-kind constants (BYTE/WORD, RD/WR).
  - Function lane_merge(word, byte, hi) returning the merged 16-bit word.
- No sub-module is needed. The whole block is a single FSM plus datapath registers.

Test Plan:
- Aligned word read at D 0x10000, memory word 0xBEEF, m_ready=1 → d_ack at N+2, d_rdata=0xBEEF, m_wr never 1.
- Unaligned fetch at f_addr 0x00003, words @0x2=0x3412, @0x4=0x7856 → f_data=0x5634, two memory cycles, f_ack at N+3.
- Byte write 0xAA at d_addr 0x00101, word @0x100=0x1234 → one read of 0x100, then a write of m_wdata=0xAA34, d_ack at N+3.
- Unaligned word write 0xCDEF at 0xFFFFF → RMW on 0xFFFFE with the high byte=0xEF, then RMW on 0x00000 with the low byte=0xCD (wrap); ack at N+5.
- f_req and d_req held continuously with back-to-back D requests → D is acked four times, the fifth grant goes to F, then the counter resets.
- m_ready held 0 for 3 cycles during RMW_WR with reset_n pulsed low → m_wr=0 immediately, no d_ack, FSM in IDLE, and a new request after reset is served normally.
